// File: rtl/irq_ctrl_wb.sv
// irq_ctrl_wb
// Wishbone-slave interrupt controller. It collects up to N_SRC external
// interrupt sources and latches each one as an edge- or level-sensitive
// pending bit. Among the enabled pending sources, the lowest index wins.
// The winner drives the core's machine external interrupt request. Software
// then runs a request / acknowledge / claim / complete handshake over the bus.
//
// Source s is reported as ID s+1. ID 0 means "no interrupt".
//
// Register map (byte address, bits [4:2] select the register):
//   0x00 PENDING  : read-only view. Writing 1 clears edge-mode bits.
//   0x04 ENABLE   : read/write, per-source enable.
//   0x08 MODE     : read/write, per source 1 = edge, 0 = level.
//   0x0C CLAIM    : read returns the winning ID and claims it.
//   0x10 COMPLETE : write-only. Ends service of the written ID.
//   0x14 STATUS   : read-only. [ID_W-1:0] = in-service ID, [17:16] = state.
//
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   wb_cyc_i, wb_stb_i Wishbone cycle / strobe
//   wb_we_i            write enable
//   wb_adr_i[4:0]      byte address
//   wb_dat_i[31:0]     write data
//   wb_dat_o[31:0]     read data, valid while wb_ack_o is high
//   wb_ack_o           single-cycle acknowledge
//   irq_src_i[N_SRC]   interrupt sources
//   irq_ack_i          core interrupt-taken pulse
//   meip_o             machine external interrupt request
//
// Optional build macro IRQ_CTRL_SYNC_EN:
//   When defined, irq_src_i passes through a 2-flop synchronizer. This makes
//   asynchronous sources safe and adds two cycles to every source-to-meip_o
//   latency. When undefined, the sources are used directly.

module irq_ctrl_wb #(
    parameter int N_SRC = 16,
    parameter int ID_W  = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic             irq_ack_i,
    output logic             meip_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_CLAIM = 2'd2,
        SERVICE    = 2'd3
    } state_t;

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_MODE     = 3'd2;
    localparam logic [2:0] REG_CLAIM    = 3'd3;
    localparam logic [2:0] REG_COMPLETE = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              meip_q, meip_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [N_SRC-1:0]  mode_q, mode_d;
    logic [N_SRC-1:0]  src_q;
    logic [ID_W-1:0]   in_service_q, in_service_d;

    logic [N_SRC-1:0]  src_in;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  win_onehot;
    logic [ID_W-1:0]   winner_id;
    logic              any_req;
    logic              access, rd, wr;
    logic [2:0]        reg_sel;
    logic              claim_rd, claim_ok, complete_ok;
    logic [N_SRC-1:0]  edge_set, edge_clr;
    logic [31:0]       status_w;
    logic [31:0]       rdata;
    logic              unused_bits;

    // Address bits [1:0] and write data above the source field carry no
    // meaning for this block.
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:N_SRC]};

`ifdef IRQ_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer so that sources may be asynchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = irq_src_i;
`endif

    // Bus decode. An access is accepted on the edge that raises the ack, and
    // all register side effects happen on that same edge. The read data and
    // the claim side effect therefore see the same winner.
    assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign rd      = access & ~wb_we_i;
    assign wr      = access & wb_we_i;
    assign reg_sel = wb_adr_i[4:2];

    // Arbitration: the lowest enabled pending index wins. The two's-complement
    // trick isolates the lowest set bit, which the claim uses to clear it.
    always_comb begin
        req        = pending_q & enable_q;
        win_onehot = req & (~req + N_SRC'(1));
        any_req    = |req;
        winner_id  = '0;
        for (int s = N_SRC - 1; s >= 0; s--) begin
            if (req[s]) begin
                winner_id = ID_W'(s + 1);
            end
        end
    end

    // A claim outside SERVICE with a real winner takes the interrupt. A claim
    // inside SERVICE returns 0 and has no side effect, because nesting is not
    // supported.
    assign claim_rd    = rd && (reg_sel == REG_CLAIM);
    assign claim_ok    = claim_rd && (state_q != SERVICE) && any_req;
    assign complete_ok = wr && (reg_sel == REG_COMPLETE) && (state_q == SERVICE)
                         && (wb_dat_i[ID_W-1:0] == in_service_q);

    // Read mux. Registers are zero-extended, so bits above N_SRC read 0.
    always_comb begin
        status_w             = '0;
        status_w[ID_W-1:0]   = in_service_q;
        status_w[17:16]      = state_q;
        rdata                = '0;
        unique case (reg_sel)
            REG_PENDING: rdata = 32'(pending_q);
            REG_ENABLE:  rdata = 32'(enable_q);
            REG_MODE:    rdata = 32'(mode_q);
            REG_CLAIM:   rdata = (state_q == SERVICE) ? 32'd0 : 32'(winner_id);
            REG_STATUS:  rdata = status_w;
            default:     rdata = '0;
        endcase
    end

    // Pending bits. Edge-mode bits are set on a rising source. They are
    // cleared by a W1C write or a claim, and a simultaneous set wins over
    // the clear. Level-mode bits simply follow the source.
    always_comb begin
        edge_set = src_in & ~src_q;
        edge_clr = '0;
        if (wr && (reg_sel == REG_PENDING)) begin
            edge_clr = edge_clr | wb_dat_i[N_SRC-1:0];
        end
        if (claim_ok) begin
            edge_clr = edge_clr | win_onehot;
        end
        pending_d = (mode_q & (edge_set | (pending_q & ~edge_clr)))
                  | (~mode_q & src_in);
    end

    // Configuration registers, bus acknowledge and read data.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr && (reg_sel == REG_ENABLE)) begin
            enable_d = wb_dat_i[N_SRC-1:0];
        end
        if (wr && (reg_sel == REG_MODE)) begin
            mode_d = wb_dat_i[N_SRC-1:0];
        end
        ack_d = access;
        dat_d = rd ? rdata : 32'd0;
    end

    // Handshake FSM. A claim has priority over the core acknowledge. In REQ,
    // a core acknowledge wins over a source dropping away, because the core
    // has already committed to the trap.
    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        if (claim_ok) begin
            in_service_d = winner_id;
        end else if (complete_ok) begin
            in_service_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (claim_ok) begin
                    state_d = SERVICE;
                end else if (any_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (claim_rd) begin
                    state_d = claim_ok ? SERVICE : IDLE;
                end else if (irq_ack_i) begin
                    state_d = WAIT_CLAIM;
                end else if (!any_req) begin
                    state_d = IDLE;
                end
            end
            WAIT_CLAIM: begin
                if (claim_rd) begin
                    state_d = claim_ok ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (complete_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        meip_d = (state_d == REQ);
    end

    // All state flops. src_q has no reset: it keeps tracking the source
    // during reset, so edges seen while in reset do not show up as new
    // edges afterwards.
    always_ff @(posedge clk_i) begin
        src_q <= src_in;
        if (reset_i) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            meip_q       <= 1'b0;
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            meip_q       <= meip_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            in_service_q <= in_service_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign meip_o   = meip_q;

endmodule
